// File: rtl/dac_bank_pkg.sv
// Shared constants for the PWM/PDM DAC bank: mode encodings, default sizes and
// the mode-register address rule.
package dac_bank_pkg;

   localparam int unsigned DEF_N_CH  = 4;
   localparam int unsigned DEF_WIDTH = 8;

   localparam logic MODE_PWM = 1'b0;
   localparam logic MODE_PDM = 1'b1;

   // The mode register sits one address above the last channel shadow code.
   function automatic int unsigned addr_mode(input int unsigned n_ch);
      return n_ch;
   endfunction

endpackage

// File: rtl/dac_channel.sv
// One DAC drive channel: active code, first-order sigma-delta accumulator and
// PWM/PDM output selection, with a registered 1-bit output.
module dac_channel
   import dac_bank_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] cnt,
   input  logic             xfer,
   input  logic [WIDTH-1:0] shadow,
   input  logic             mode,
   input  logic             clr,
   output logic             dac
);

   logic [WIDTH-1:0] active;
   logic [WIDTH:0]   acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= '0;
         acc    <= '0;
         dac    <= 1'b0;
      end else begin
         if (xfer) begin
            active <= shadow;
         end
         // Carry of the previous step is dropped; only the low WIDTH bits accumulate.
         if (!en || clr) begin
            acc <= '0;
         end else begin
            acc <= {1'b0, acc[WIDTH-1:0]} + {1'b0, active};
         end
         if (!en) begin
            dac <= 1'b0;
         end else if (mode == MODE_PDM) begin
            dac <= acc[WIDTH];
         end else begin
            dac <= (cnt < active);
         end
      end
   end

endmodule

// File: rtl/dac_bank_pdm.sv
// Bank of PWM/PDM DAC channels with byte-wide shadow code writes and atomic
// commit of all shadow codes at the frame boundary.
module dac_bank_pdm
   import dac_bank_pkg::*;
#(
   parameter int unsigned N_CH   = DEF_N_CH,
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              commit,
   output logic [N_CH-1:0]   dac_out,
   output logic              frame_tick,
   output logic              commit_pending
);

   localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
   localparam logic [ADDR_W-1:0] MODE_ADDR = ADDR_W'(addr_mode(N_CH));

   logic [WIDTH-1:0] shadow [N_CH];
   logic [N_CH-1:0]  mode;
   logic [WIDTH-1:0] cnt;
   logic             wrap_c;
   logic             xfer_c;
   logic             mode_wr_c;

   assign wrap_c    = en && (cnt == CNT_MAX);
   // A commit landing on the wrap cycle transfers immediately without pending.
   assign xfer_c    = wrap_c && (commit_pending || commit);
   assign mode_wr_c = wr_en && (wr_addr == MODE_ADDR);

   // Frame counter, frame tick and commit tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= '0;
         frame_tick     <= 1'b0;
         commit_pending <= 1'b0;
      end else begin
         cnt        <= en ? cnt + WIDTH'(1) : '0;
         frame_tick <= wrap_c;
         if (xfer_c) begin
            commit_pending <= 1'b0;
         end else if (commit) begin
            commit_pending <= 1'b1;
         end
      end
   end

   // Shadow codes and mode register; writes land regardless of en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            shadow[i] <= '0;
         end
         mode <= '0;
      end else begin
         for (int i = 0; i < int'(N_CH); i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
               shadow[i] <= wr_data;
            end
         end
         if (mode_wr_c) begin
            mode <= wr_data[N_CH-1:0];
         end
      end
   end

   for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
      dac_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .cnt   (cnt),
         .xfer  (xfer_c),
         .shadow(shadow[g]),
         .mode  (mode[g]),
         .clr   (mode_wr_c),
         .dac   (dac_out[g])
      );
   end

endmodule

// File: tb/tb_dac_bank_pdm.sv
// Self-checking bench for dac_bank_pdm: directed scenarios with literal duty and
// timing expectations, then randomized traffic against a cycle-level model.
module tb_dac_bank_pdm;

   localparam int N_CH   = 4;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = 4;
   localparam int FRAME  = 256;
   localparam int FMAX   = FRAME - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic              commit;
   logic [N_CH-1:0]   dac_out;
   logic              frame_tick;
   logic              commit_pending;

   dac_bank_pdm #(.N_CH(N_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .commit        (commit),
      .dac_out       (dac_out),
      .frame_tick    (frame_tick),
      .commit_pending(commit_pending)
   );

   always #5 clk = ~clk;

   // Reference model: integer frame position, codes and accumulators.
   int            m_cnt;
   int            m_shadow [N_CH];
   int            m_active [N_CH];
   int            m_acc    [N_CH];
   bit [N_CH-1:0] m_mode;
   bit [N_CH-1:0] m_dac;
   bit            m_tick;
   bit            m_pend;
   logic          m_wrap, m_xfer, m_mode_wr;

   assign m_wrap    = en && (m_cnt == FMAX);
   assign m_xfer    = m_wrap && (m_pend || commit);
   assign m_mode_wr = wr_en && (int'(wr_addr) == N_CH);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_mode <= '0;
         m_dac  <= '0;
         m_tick <= 1'b0;
         m_pend <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            m_shadow[i] <= 0;
            m_active[i] <= 0;
            m_acc[i]    <= 0;
         end
      end else begin
         m_cnt  <= en ? (m_cnt + 1) % FRAME : 0;
         m_tick <= m_wrap;
         m_pend <= m_xfer ? 1'b0 : (m_pend || commit);
         if (m_mode_wr) m_mode <= wr_data[N_CH-1:0];
         for (int i = 0; i < N_CH; i++) begin
            if (m_xfer) m_active[i] <= m_shadow[i];
            if (wr_en && int'(wr_addr) == i) m_shadow[i] <= int'(wr_data);
            m_acc[i] <= (!en || m_mode_wr) ? 0 : (m_acc[i] % FRAME) + m_active[i];
            m_dac[i] <= en && (m_mode[i] ? (m_acc[i] >= FRAME) : (m_cnt < m_active[i]));
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Advance one cycle and compare every output against the model.
   task automatic step();
      @(negedge clk);
      if (rst_n) begin
         chk("dac_out", int'(dac_out), int'(m_dac));
         chk("frame_tick", int'(frame_tick), int'(m_tick));
         chk("commit_pending", int'(commit_pending), int'(m_pend));
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic do_write(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_data = WIDTH'(d);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   // Wait for a pending commit to transfer; it must clear together with frame_tick.
   task automatic wait_xfer();
      int  n;
      bit  was_pend;
      n        = 0;
      was_pend = m_pend;
      while (m_pend && n < 2 * FRAME) begin
         step();
         n++;
      end
      if (m_pend) chk("xfer_timeout", 1, 0);
      else if (was_pend) chk("pend_clr_with_tick", int'(frame_tick), 1);
   endtask

   task automatic wait_cnt(input int c);
      int n;
      n = 0;
      while (m_cnt != c && n < 2 * FRAME) begin
         step();
         n++;
      end
      if (m_cnt != c) chk("cnt_timeout", m_cnt, c);
   endtask

   task automatic count_ch(input int ch, output int hi);
      hi = 0;
      repeat (FRAME) begin
         step();
         hi += int'(dac_out[ch]);
      end
   endtask

   initial begin
      int hi;
      int n;
      bit prev;
      rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
      steps(3);
      chk("rst_dac_out", int'(dac_out), 0);
      chk("rst_frame_tick", int'(frame_tick), 0);
      chk("rst_pending", int'(commit_pending), 0);
      rst_n = 1'b1;
      en    = 1'b1;
      step();

      // PWM duty 64/256.
      do_write(0, 64);
      do_commit();
      chk("pending_set", int'(commit_pending), 1);
      wait_xfer();
      steps(2);
      count_ch(0, hi);
      chk("pwm64_duty", hi, 64);

      // Double buffering: shadow write without commit leaves duty alone.
      do_write(1, 32);
      do_commit();
      wait_xfer();
      do_write(1, 200);
      steps(2);
      count_ch(1, hi);
      chk("dbuf_old_duty", hi, 32);
      do_commit();
      wait_xfer();
      steps(2);
      count_ch(1, hi);
      chk("dbuf_new_duty", hi, 200);

      // PDM density and alternation on ch0.
      do_write(N_CH, 1);
      do_write(0, 1);
      do_commit();
      wait_xfer();
      steps(3);
      count_ch(0, hi);
      chk("pdm1_density", hi, 1);
      do_write(0, 128);
      do_commit();
      wait_xfer();
      do_write(N_CH, 1);
      steps(3);
      prev = dac_out[0];
      for (int k = 0; k < 8; k++) begin
         step();
         chk("pdm128_alt", int'(dac_out[0]), int'(!prev));
         prev = dac_out[0];
      end

      // Extremes: code 0 in both modes, code 255 in PWM.
      do_write(N_CH, 9);
      steps(3);
      count_ch(3, hi);
      chk("pdm0_const", hi, 0);
      do_write(N_CH, 0);
      steps(3);
      count_ch(3, hi);
      chk("pwm0_const", hi, 0);
      do_write(2, 255);
      do_commit();
      wait_xfer();
      steps(2);
      count_ch(2, hi);
      chk("pwm255_duty", hi, 255);
      n = 0;
      while (!m_tick && n < 2 * FRAME) begin
         step();
         n++;
      end
      chk("pwm255_low_at_wrap", int'(dac_out[2]), 0);

      // Commit and shadow write on the wrap cycle itself.
      do_write(2, 10);
      do_commit();
      wait_xfer();
      wait_cnt(FMAX);
      commit = 1'b1; wr_en = 1'b1; wr_addr = ADDR_W'(2); wr_data = WIDTH'(99);
      step();
      commit = 1'b0; wr_en = 1'b0;
      chk("simul_no_pending", int'(commit_pending), 0);
      steps(2);
      count_ch(2, hi);
      chk("simul_old_shadow", hi, 10);
      do_commit();
      wait_xfer();
      steps(2);
      count_ch(2, hi);
      chk("simul_second_commit", hi, 99);

      // Enable drop mid-frame with a commit pending.
      do_write(1, 77);
      wait_cnt(100);
      do_commit();
      steps(10);
      en = 1'b0;
      step();
      chk("en_off_dac", int'(dac_out), 0);
      chk("en_off_pending", int'(commit_pending), 1);
      steps(20);
      chk("en_off_pending_held", int'(commit_pending), 1);
      en = 1'b1;
      n  = 0;
      do begin
         step();
         n++;
      end while (!frame_tick && n < 2 * FRAME);
      chk("restart_frame_len", n, FRAME);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(299) == 0) en = ~en;
         wr_en   = ($urandom_range(5) == 0);
         wr_addr = ($urandom_range(15) == 0) ? ADDR_W'(15) : ADDR_W'($urandom_range(7));
         wr_data = WIDTH'($urandom);
         commit  = ($urandom_range(99) == 0);
         step();
      end
      wr_en = 1'b0;
      en    = 1'b1;
      commit = 1'b1;
      step();
      commit = 1'b0;
      steps(5);

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_dac", int'(dac_out), 0);
      chk("async_rst_tick", int'(frame_tick), 0);
      chk("async_rst_pending", int'(commit_pending), 0);
      @(negedge clk);
      rst_n = 1'b1;
      steps(5);
      chk("post_rst_pending", int'(commit_pending), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_bank_pdm.md
Name: dac_bank_pdm

Overview:
- Parametrised bank of N_CH digital-to-analog drive channels. Each channel produces a 1-bit stream for off-chip or on-die RC filtering onto the analog pins.
- Each channel runs either PWM or first-order sigma-delta (PDM) mode.
- Codes are double-buffered: written to shadow registers over a simple byte write port, then committed atomically at a frame boundary.
- Sits between the top-level pin wrapper (ui_in/uio_in decode) and the analog pad drivers.

Parameters:
- N_CH, 4, number of output channels (1..8)
- WIDTH, 8, code width in bits; frame length is 2^WIDTH cycles
- ADDR_W, 4, write address width; must satisfy 2^ADDR_W > N_CH

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes and clears the modulators
- wr_en  in  1  write strobe, sampled on rising clk
- wr_addr  in  ADDR_W  0..N_CH-1 selects a channel shadow code; N_CH selects the mode register
- wr_data  in  WIDTH  write data
- commit  in  1  one-cycle request to transfer shadow to active at the next frame boundary
- dac_out  out  N_CH  registered modulator outputs
- frame_tick  out  1  one-cycle pulse on the cycle the frame counter wraps to 0
- commit_pending  out  1  high from commit acceptance until the transfer completes

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, named rst_n.
- Reset values: all shadow, active and mode registers = 0; frame counter = 0; accumulators = 0; dac_out = 0; frame_tick = 0; commit_pending = 0.
- Writes:
  - wr_en with wr_addr < N_CH sets shadow[wr_addr] = wr_data.
  - wr_addr == N_CH sets mode[N_CH-1:0] = wr_data[N_CH-1:0]. Per channel, 0 = PWM and 1 = PDM. Mode takes effect immediately; it is not buffered.
  - wr_addr > N_CH is ignored.
- Frame counter: cnt is WIDTH bits and increments every cycle while en = 1, wrapping 2^WIDTH-1 -> 0.
- frame_tick: registered, high in the cycle cnt == 0 follows a wrap.
- Commit:
  - commit = 1 sets commit_pending.
  - On the wrap edge (cnt == 2^WIDTH-1 and en = 1) with pending set, active[i] <= shadow[i] for all channels simultaneously, and pending clears.
  - If commit arrives on the wrap cycle itself, the transfer happens on that edge and pending never rises.
  - A shadow write on the transfer edge is not included. Active takes the pre-write shadow value; the new shadow value waits for the next commit.
- PWM: out_i = (cnt < active[i]).
  - active = 0 gives a constant 0.
  - active = 2^WIDTH-1 gives high for 2^WIDTH-1 cycles out of 2^WIDTH.
- PDM: acc_i is a WIDTH+1 bit accumulator with acc_i <= {0, acc_i[WIDTH-1:0]} + active[i]; out_i = acc_i[WIDTH] (carry). Mean density is active / 2^WIDTH.
- Mode change mid-frame: the channel's accumulator is cleared on the edge the mode register is written.
- Output timing: dac_out is registered, so output lags the compare/carry by 1 cycle.
- en = 0:
  - cnt held at 0, accumulators cleared, dac_out forced to 0 next cycle.
  - No frame_tick and no commit transfer; pending is kept.
  - Writes still land in shadow/mode.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values; the pending commit is lost.

Decomposition:
- Package dac_bank_pkg holds:
  - mode encodings MODE_PWM = 0 and MODE_PDM = 1
  - address constant ADDR_MODE = N_CH (computed function)
  - default WIDTH/N_CH constants
- Sub-module dac_channel:
  - one per channel, generated N_CH times
  - holds the active code, PDM accumulator and mode mux
  - takes cnt, wrap/transfer strobe, shadow value, mode bit and en
- The top holds the shadow array, mode register, frame counter and commit logic.

Test Plan:
- PWM duty: write ch0 = 64, commit, run 2 frames -> from the first full frame after the transfer, dac_out[0] high exactly 64 of every 256 cycles; commit_pending clears on the wrap edge.
- Double buffering: active ch1 = 32; write shadow ch1 = 200 with no commit -> output stays at 32/256 duty; after commit the new duty is 200/256 from the next frame start only.
- PDM density: mode = 0b0001, ch0 = 1 -> exactly one high cycle per 256; ch0 = 128 -> strict alternation 0,1,0,1 after the accumulator clears.
- Extremes: code 0 -> constant 0 in both modes; code 255 in PWM -> one low cycle per frame, at cnt = 255 (seen one cycle later at the output).
- Simultaneous events: commit on the wrap cycle together with a shadow write ch2 = 99 (old shadow 10) -> active ch2 = 10, pending never asserted; a second commit -> 99.
- Enable/reset: deassert en mid-frame -> dac_out = 0 next cycle, cnt = 0, pending held; reassert -> frame restarts at 0. Assert rst_n low asynchronously -> all outputs 0 without a clock edge.
